// File: rtl/snes_pad_responder.sv
// Controller-side SNES pad: answers a host's latch/clock with a 16-bit active-low frame.
// Both protocol inputs are asynchronous and oversampled on the system clock.
module snes_pad_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_latch,
   input  logic        snes_clk,
   input  logic [11:0] buttons,
   output logic        serial_data,
   output logic        frame_done,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] lat_sync_q, lat_sync_d;
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic                   lat_hist_q, lat_hist_d;
   logic                   clk_hist_q, clk_hist_d;
   logic [15:0]            frame_q, frame_d;
   logic [4:0]             cnt_q, cnt_d;
   logic                   frame_done_q, frame_done_d;
   logic                   busy_q, busy_d;

   logic lat_s, clk_s, lat_fall, clk_rise;
   logic [15:0] snapshot;

   assign lat_s    = lat_sync_q[SYNC_STAGES-1];
   assign clk_s    = clk_sync_q[SYNC_STAGES-1];
   assign lat_fall = ~lat_s & lat_hist_q;
   assign clk_rise = clk_s & ~clk_hist_q;
   // Upper nibble is the standard-pad ID, always released.
   assign snapshot = {4'b1111, ~buttons};

   always_comb begin
      lat_sync_d = {lat_sync_q[SYNC_STAGES-2:0], data_latch};
      clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], snes_clk};
      lat_hist_d = lat_s;
      clk_hist_d = clk_s;
   end

   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            frame_d = 16'hFFFF;
            if (lat_s) begin
               state_d = ST_LATCH;
               frame_d = snapshot;
               cnt_d   = 5'd0;
            end
         end
         ST_LATCH: begin
            // A coincident clock rise is dropped so B stays presented.
            frame_d = snapshot;
            cnt_d   = 5'd0;
            if (lat_fall) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (lat_s) begin
               state_d = ST_LATCH;
               frame_d = snapshot;
               cnt_d   = 5'd0;
            end else if (clk_rise) begin
               frame_d = {1'b0, frame_q[15:1]};
               cnt_d   = (cnt_q == 5'd16) ? 5'd16 : cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  state_d      = ST_DONE;
                  frame_done_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            frame_d = 16'h0000;
            if (lat_s) begin
               state_d = ST_LATCH;
               frame_d = snapshot;
               cnt_d   = 5'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            frame_d = 16'hFFFF;
            cnt_d   = 5'd0;
         end
      endcase
      busy_d = (state_d == ST_LATCH) || (state_d == ST_SHIFT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         lat_sync_q   <= '0;
         clk_sync_q   <= '1;
         lat_hist_q   <= 1'b0;
         clk_hist_q   <= 1'b1;
         frame_q      <= 16'hFFFF;
         cnt_q        <= 5'd0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_sync_q   <= lat_sync_d;
         clk_sync_q   <= clk_sync_d;
         lat_hist_q   <= lat_hist_d;
         clk_hist_q   <= clk_hist_d;
         frame_q      <= frame_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign serial_data = frame_q[0];
   assign frame_done  = frame_done_q;
   assign busy        = busy_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Bench for snes_pad_responder: acts as the SNES host and compares every shifted bit
// against a frame model built from the button snapshot.
module tb_snes_pad_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_latch;
   logic        snes_clk;
   logic [11:0] buttons;
   logic        serial_data;
   logic        frame_done;
   logic        busy;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;
   int done_cycles = 0;
   logic [0:0] exp_q[$];

   snes_pad_responder #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .data_latch  (data_latch),
      .snes_clk    (snes_clk),
      .buttons     (buttons),
      .serial_data (serial_data),
      .frame_done  (frame_done),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   // clock / reset block
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_done === 1'b1) done_cycles++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bit i of the frame the host sees after i shift-clock rises.
   function automatic logic pad_bit(input logic [11:0] snap, input int i);
      if (i < 12) return ~snap[i];
      else if (i < 16) return 1'b1;
      else return 1'b0;
   endfunction

   task automatic load_expect(input logic [11:0] snap);
      exp_q.delete();
      for (int i = 0; i < 24; i++) exp_q.push_back(pad_bit(snap, i));
   endtask

   // driver: latch pulse; with coincide the latch fall and clock rise share one instant
   task automatic drive_latch(input logic [11:0] btn, input int len, input bit coincide);
      buttons    = btn;
      data_latch = 1'b1;
      if (coincide) snes_clk = 1'b0;
      wait_cyc(len);
      data_latch = 1'b0;
      if (coincide) snes_clk = 1'b1;
   endtask

   // driver: n shift pulses, sampling serial_data as snes_clk falls
   task automatic drive_clocks(input int n, input int half, input string tag);
      logic [0:0] e;
      for (int k = 0; k < n; k++) begin
         wait_cyc(half);
         e = exp_q.pop_front();
         check($sformatf("%s_bit%0d", tag, k), serial_data, e);
         if (k == 0) check($sformatf("%s_busy", tag), busy, 1);
         snes_clk = 1'b0;
         wait_cyc(half);
         snes_clk = 1'b1;
      end
   endtask

   task automatic run_frame(input logic [11:0] btn, input logic [11:0] later_btn, input int len,
                            input int half, input int n, input bit coincide, input string tag);
      int d0;
      d0 = done_cycles;
      drive_latch(btn, len, coincide);
      load_expect(btn);
      wait_cyc(4);
      buttons = later_btn;
      drive_clocks(n, half, tag);
      wait_cyc(half);
      check($sformatf("%s_done_cnt", tag), done_cycles - d0, (n >= 16) ? 1 : 0);
      if (n >= 16) begin
         check($sformatf("%s_tail_zero", tag), serial_data, 0);
         check($sformatf("%s_idle_busy", tag), busy, 0);
      end
   endtask

   initial begin
      int idle_bad;
      int busy_low;
      int d0;
      logic [11:0] ra, rb;
      reset      = 1'b0;
      data_latch = 1'b0;
      snes_clk   = 1'b1;
      buttons    = 12'h000;
      wait_cyc(3);
      check("rst_serial", serial_data, 1);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_state", state_dbg, 0);
      reset = 1'b1;

      idle_bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (serial_data !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) idle_bad++;
      end
      check("idle_stable", idle_bad, 0);

      run_frame(12'h0A5, 12'h0A5, 600, 300, 16, 1'b0, "full");
      run_frame(12'hFFF, 12'h000, 40, 20, 16, 1'b0, "snapshot");
      run_frame(12'h3C9, 12'h3C9, 30, 12, 20, 1'b0, "overclock");
      run_frame(12'h001, 12'h001, 30, 12, 16, 1'b1, "coincide");

      // abort: relatch after 5 pulses, busy must never drop
      d0 = done_cycles;
      ra = 12'($urandom);
      rb = 12'($urandom);
      drive_latch(ra, 30, 1'b0);
      load_expect(ra);
      drive_clocks(5, 10, "abort_pre");
      data_latch = 1'b1;
      busy_low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_low++;
      end
      check("abort_busy", busy_low, 0);
      check("abort_state", state_dbg, 1);
      buttons    = rb;
      data_latch = 1'b0;
      load_expect(rb);
      drive_clocks(16, 10, "abort_post");
      wait_cyc(10);
      check("abort_done_cnt", done_cycles - d0, 1);
      check("abort_tail", serial_data, 0);

      for (int f = 0; f < 6; f++) begin
         run_frame(12'($urandom), 12'($urandom), $urandom_range(6, 60), $urandom_range(6, 40),
                   $urandom_range(16, 20), 1'($urandom_range(0, 1)), $sformatf("rand%0d", f));
      end

      // asynchronous reset in the middle of a frame
      drive_latch(12'hFFF, 20, 1'b0);
      load_expect(12'hFFF);
      drive_clocks(7, 10, "midrst");
      wait_cyc(5);
      check("midrst_pre", serial_data, 0);
      #2 reset = 1'b0;
      #1;
      check("midrst_serial", serial_data, 1);
      check("midrst_busy", busy, 0);
      check("midrst_done", frame_done, 0);
      check("midrst_state", state_dbg, 0);
      data_latch = 1'b0;
      snes_clk   = 1'b1;
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(3);
      run_frame(12'h5A3, 12'h5A3, 25, 9, 16, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout observed=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
